// File: rtl/vedic_pkg.sv
// Shared types and constants for the Vedic multiplier datapath and its product accumulator.
package vedic_pkg;

    localparam int DEF_PROD_W = 8;
    localparam int DEF_ACC_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // A single-product frame still needs one counter bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/product_accumulator_acc_adder.sv
// Combinational ACC_W+1 bit add of accumulator and zero-extended product.
// ACC_SATURATE_EN clamps the sum to all-ones on carry out; otherwise it wraps.
module acc_adder #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] product,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);

    logic [ACC_W:0] wide;

    assign wide  = {1'b0, acc} + {1'b0, ACC_W'(product)};
    assign carry = wide[ACC_W];

`ifdef ACC_SATURATE_EN
    // Once clamped, any further non-zero product carries again, so the clamp holds.
    assign sum = carry ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
    assign sum = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Sums COUNT consecutive products per start-triggered frame with valid/ready on both sides.
// Optional build macro ACC_SATURATE_EN selects saturating instead of wrapping accumulation.
module product_accumulator
    import vedic_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int COUNT  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [PROD_W-1:0] product,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              busy,
    output logic              overflow
);

    localparam int CW = cnt_width(COUNT);

    // Handshake rule: a transfer happens on a rising edge where valid and ready are both high;
    // ready and valid outputs here are decoded from state only.

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] sum;
    logic             carry;
    logic [CW-1:0]    cnt_q;
    logic             ovf_q;
    logic [ACC_W-1:0] acc_out_q;
    logic             xfer;
    logic             last;
    logic             done_hs;
    logic             frame_start;

    assign xfer        = (state == ACCUM) && prod_valid;
    assign last        = xfer && (cnt_q == CW'(COUNT - 1));
    assign done_hs     = (state == DONE) && acc_ready;
    assign frame_start = ((state == IDLE) && start) || (done_hs && start);

    acc_adder #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_adder (
        .acc     (acc_q),
        .product (product),
        .sum     (sum),
        .carry   (carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (last) state_nxt = DONE;
            DONE:    if (acc_ready) state_nxt = start ? ACCUM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            acc_out_q <= '0;
        end else if (frame_start) begin
            acc_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (xfer) begin
            acc_q <= sum;
            cnt_q <= cnt_q + CW'(1);
            if (carry) ovf_q <= 1'b1;
            if (last)  acc_out_q <= sum;
        end
    end

    assign prod_ready = (state == ACCUM);
    assign acc_valid  = (state == DONE);
    assign busy       = (state != IDLE);
    assign acc_out    = acc_out_q;
    assign overflow   = ovf_q;

endmodule
